// File: rtl/sp_ram_arbiter_if.sv
// Per-requester command/response bundle for sp_ram_arbiter.
// The master side is the requester; the slave side is the arbiter.
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, resp_valid, resp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each access takes three cycles: handshake, RAM enable, response.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_ram_arbiter_if.slave       req0,
  sp_ram_arbiter_if.slave       req1,
  output logic                  ram_cs_n,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  logic                  last_grant;
  logic                  cmd_idx;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  grant_valid;
  logic                  grant_idx;

  // When both requesters are valid, the one not served last wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (state == IDLE) begin
      grant_valid = req0.valid | req1.valid;
      grant_idx   = (req0.valid && req1.valid) ? ~last_grant : req1.valid;
    end
  end

  assign req0.ready = grant_valid & ~grant_idx;
  assign req1.ready = grant_valid &  grant_idx;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      cmd_idx         <= 1'b0;
      cmd_we          <= 1'b0;
      cmd_addr        <= '0;
      cmd_wdata       <= '0;
      ram_cs_n        <= 1'b1;
      ram_we          <= 1'b0;
      req0.resp_valid <= 1'b0;
      req1.resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= ACCESS;
            last_grant <= grant_idx;
            cmd_idx    <= grant_idx;
            cmd_we     <= grant_idx ? req1.we    : req0.we;
            cmd_addr   <= grant_idx ? req1.addr  : req0.addr;
            cmd_wdata  <= grant_idx ? req1.wdata : req0.wdata;
            ram_cs_n   <= 1'b0;
            ram_we     <= grant_idx ? req1.we    : req0.we;
          end
        end
        ACCESS: begin
          state           <= RESP;
          ram_cs_n        <= 1'b1;
          ram_we          <= 1'b0;
          req0.resp_valid <= ~cmd_idx;
          req1.resp_valid <=  cmd_idx;
        end
        RESP: begin
          state           <= IDLE;
          req0.resp_valid <= 1'b0;
          req1.resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_addr = cmd_addr;
  assign ram_din  = cmd_wdata;
  assign busy     = (state != IDLE);

  // RAM read data arrives registered, i.e. exactly during RESP; writes acknowledge with zero.
  assign req0.resp_rdata = (req0.resp_valid && !cmd_we) ? ram_dout : '0;
  assign req1.resp_rdata = (req1.resp_valid && !cmd_we) ? ram_dout : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: directed scenarios plus a randomized
// run against a cycle-countdown reference model with a shadow copy of RAM.
module tb_sp_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0 ();
  sp_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1 ();

  logic          ram_cs_n, ram_we, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req0(r0), .req1(r1),
    .ram_cs_n(ram_cs_n), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  // Synchronous RAM with registered read data.
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  always @(posedge clk) begin
    if (!ram_cs_n) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  logic [DW-1:0] shadow [2**AW] = '{default: '0};
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i == 0) begin
      r0.valid = v; r0.we = we; r0.addr = a; r0.wdata = d;
    end else begin
      r1.valid = v; r1.we = we; r1.addr = a; r1.wdata = d;
    end
  endtask

  function automatic logic rdy(input int i);
    return (i != 0) ? r1.ready : r0.ready;
  endfunction
  function automatic logic rv(input int i);
    return (i != 0) ? r1.resp_valid : r0.resp_valid;
  endfunction
  function automatic logic [DW-1:0] rd(input int i);
    return (i != 0) ? r1.resp_rdata : r0.resp_rdata;
  endfunction

  // One complete access by requester i with cycle-exact checks of T, T+1, T+2, T+3.
  task automatic access(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int n = 0;
    logic [DW-1:0] exp_rdata;
    drive(i, 1'b1, we, a, d);
    #1;
    while (!rdy(i) && n < 20) begin tick(); n++; end
    total++;
    if (!rdy(i)) begin
      bad++; $display("FAIL grant_timeout req%0d: ready=%b required 1", i, rdy(i));
      drive(i, 1'b0, 1'b0, '0, '0);
      return;
    end
    total++; if (rdy(1-i) !== 1'b0) begin bad++; $display("FAIL other_ready req%0d: got %b want 0", 1-i, rdy(1-i)); end
    exp_rdata = we ? '0 : shadow[a];
    tick();
    drive(i, 1'b0, 1'b0, '0, '0);
    #1;
    total++; if (ram_cs_n !== 1'b0) begin bad++; $display("FAIL access_cs_n: got %b want 0", ram_cs_n); end
    total++; if (ram_we !== we) begin bad++; $display("FAIL access_we: got %b want %b", ram_we, we); end
    total++; if (ram_addr !== a) begin bad++; $display("FAIL access_addr: got %0d want %0d", ram_addr, a); end
    if (we) begin
      total++; if (ram_din !== d) begin bad++; $display("FAIL access_din: got %h want %h", ram_din, d); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL access_busy: got %b want 1", busy); end
    total++; if ({rv(1), rv(0)} !== 2'b00) begin bad++; $display("FAIL access_resp: got %b want 00", {rv(1), rv(0)}); end
    tick();
    if (we) shadow[a] = d;
    total++; if (rv(i) !== 1'b1) begin bad++; $display("FAIL resp_valid req%0d: got %b want 1", i, rv(i)); end
    total++; if (rv(1-i) !== 1'b0) begin bad++; $display("FAIL resp_other req%0d: got %b want 0", 1-i, rv(1-i)); end
    total++; if (rd(i) !== exp_rdata) begin bad++; $display("FAIL resp_rdata req%0d addr %0d: got %h want %h", i, a, rd(i), exp_rdata); end
    total++; if (busy !== 1'b1 || ram_cs_n !== 1'b1 || ram_we !== 1'b0) begin
      bad++; $display("FAIL resp_ram_idle: busy=%b cs_n=%b we=%b want 1 1 0", busy, ram_cs_n, ram_we); end
    tick();
    total++; if ({rv(1), rv(0), busy} !== 3'b000) begin bad++; $display("FAIL idle_after: resp/busy=%b want 000", {rv(1), rv(0), busy}); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    tick(); tick();
    total++; if ({ram_cs_n, ram_we} !== 2'b10) begin bad++; $display("FAIL reset_ram_ctl: got %b want 10", {ram_cs_n, ram_we}); end
    total++; if (ram_addr !== '0 || ram_din !== '0) begin bad++; $display("FAIL reset_ram_bus: addr=%0d din=%h want 0", ram_addr, ram_din); end
    total++; if ({busy, rv(0), rv(1)} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", {busy, rv(0), rv(1)}); end
    total++; if (rd(0) !== '0 || rd(1) !== '0) begin bad++; $display("FAIL reset_rdata: got %h %h want 0", rd(0), rd(1)); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 6'd5, 64'hA5);
    access(1, 1'b0, 6'd5, '0);
  endtask

  task automatic test_boundary();
    access(0, 1'b1, 6'd0, {$urandom, $urandom});
    access(0, 1'b1, 6'd63, '1);
    access(0, 1'b0, 6'd63, '0);
    access(1, 1'b0, 6'd0, '0);
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int last = 1;
    int prev_cyc = -1;
    do_reset();
    drive(0, 1'b1, 1'b0, 6'($urandom), '0);
    drive(1, 1'b1, 1'b0, 6'($urandom), '0);
    #1;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      if (r0.ready || r1.ready) begin
        total++; if (r0.ready && r1.ready) begin bad++; $display("FAIL rr_both_ready: cycle %0d", cyc); end
        total++; if (int'(r1.ready) != 1 - last) begin bad++; $display("FAIL rr_order grant %0d: got req%0d want req%0d", grants, int'(r1.ready), 1 - last); end
        if (prev_cyc >= 0) begin
          total++; if (cyc - prev_cyc != 3) begin bad++; $display("FAIL rr_spacing: got %0d want 3", cyc - prev_cyc); end
        end
        last = 1 - last;
        prev_cyc = cyc;
        grants++;
      end
      tick();
    end
    total++; if (grants != 4) begin bad++; $display("FAIL rr_count: got %0d want 4", grants); end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    drive(0, 1'b1, 1'b1, 6'd7, 64'hDEAD_BEEF);
    #1;
    while (!r0.ready && n < 20) begin tick(); n++; end
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    total++; if (ram_cs_n !== 1'b0) begin bad++; $display("FAIL abort_in_access: cs_n=%b want 0", ram_cs_n); end
    rst_n = 1'b0;
    #1;
    total++; if ({ram_cs_n, ram_we, busy} !== 3'b100) begin bad++; $display("FAIL abort_ctl: cs_n/we/busy=%b want 100", {ram_cs_n, ram_we, busy}); end
    total++; if (ram_addr !== '0 || ram_din !== '0) begin bad++; $display("FAIL abort_bus: addr=%0d din=%h want 0", ram_addr, ram_din); end
    tick();
    total++; if ({rv(0), rv(1)} !== 2'b00) begin bad++; $display("FAIL abort_resp_in_reset: got %b want 00", {rv(0), rv(1)}); end
    rst_n = 1'b1;
    tick();
    total++; if ({rv(0), rv(1), busy} !== 3'b000) begin bad++; $display("FAIL abort_resp_after: got %b want 000", {rv(0), rv(1), busy}); end
    drive(0, 1'b1, 1'b0, 6'd1, '0);
    drive(1, 1'b1, 1'b0, 6'd2, '0);
    #1;
    total++; if ({r1.ready, r0.ready} !== 2'b01) begin bad++; $display("FAIL abort_first_grant: ready1/0=%b want 01", {r1.ready, r0.ready}); end
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick(); tick();
  endtask

  task automatic test_wait_during_access();
    int n = 0;
    logic [DW-1:0] d = {$urandom, $urandom};
    drive(0, 1'b1, 1'b1, 6'd9, d);
    #1;
    while (!r0.ready && n < 20) begin tick(); n++; end
    tick();
    shadow[9] = d;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, 6'd9, '0);
    #1;
    total++; if (r1.ready !== 1'b0) begin bad++; $display("FAIL wait_ready_access: got %b want 0", r1.ready); end
    tick();
    total++; if (r1.ready !== 1'b0) begin bad++; $display("FAIL wait_ready_resp: got %b want 0", r1.ready); end
    tick();
    total++; if (r1.ready !== 1'b1) begin bad++; $display("FAIL wait_ready_idle: got %b want 1", r1.ready); end
    tick();
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    total++; if (r1.resp_valid !== 1'b1 || r1.resp_rdata !== shadow[9]) begin
      bad++; $display("FAIL wait_resp: valid=%b rdata=%h want 1 %h", r1.resp_valid, r1.resp_rdata, shadow[9]); end
    tick();
  endtask

  // Reference model: an access occupies the block for two cycles after its handshake.
  task automatic test_random();
    int busy_left = 0;
    int last = 1;
    int pend_idx = 0;
    logic pend_we = 1'b0;
    logic [DW-1:0] pend_rdata = '0;
    logic [1:0] v;
    logic [1:0] w;
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = 2'($urandom_range(0, 3));
      w = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        a[k] = 6'($urandom_range(0, 7) * 9);
        d[k] = {$urandom, $urandom};
        drive(k, v[k], w[k], a[k], d[k]);
      end
      #1;
      total++; if (busy !== (busy_left != 0)) begin bad++; $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, busy, busy_left != 0); end
      total++; if (ram_cs_n !== (busy_left != 2)) begin bad++; $display("FAIL rnd_cs_n cyc %0d: got %b want %b", cyc, ram_cs_n, busy_left != 2); end
      if (busy_left == 1) begin
        total++; if (rv(pend_idx) !== 1'b1 || rv(1 - pend_idx) !== 1'b0) begin
          bad++; $display("FAIL rnd_resp cyc %0d: resp1/0=%b for req%0d", cyc, {rv(1), rv(0)}, pend_idx); end
        total++; if (rd(pend_idx) !== (pend_we ? '0 : pend_rdata)) begin
          bad++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", cyc, rd(pend_idx), pend_we ? '0 : pend_rdata); end
      end else begin
        total++; if ({rv(1), rv(0)} !== 2'b00) begin bad++; $display("FAIL rnd_no_resp cyc %0d: got %b want 00", cyc, {rv(1), rv(0)}); end
      end
      if (busy_left == 0 && v != 2'b00) begin
        int g = (v == 2'b11) ? 1 - last : int'(v[1]);
        total++; if ({r1.ready, r0.ready} !== 2'(1 << g)) begin
          bad++; $display("FAIL rnd_grant cyc %0d: ready1/0=%b want req%0d", cyc, {r1.ready, r0.ready}, g); end
        last = g;
        pend_idx = g;
        pend_we = w[g];
        pend_rdata = shadow[a[g]];
        if (w[g]) shadow[a[g]] = d[g];
        busy_left = 2;
      end else begin
        total++; if ({r1.ready, r0.ready} !== 2'b00) begin bad++; $display("FAIL rnd_no_ready cyc %0d: got %b want 00", cyc, {r1.ready, r0.ready}); end
        if (busy_left > 0) busy_left--;
      end
      tick();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick(); tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_boundary();
    test_round_robin();
    test_reset_mid_access();
    test_wait_during_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SHALL set the RAM word-address width (RAM depth 2^ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the RAM and requester data width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Ports reqN_valid  input  1 (N=0,1) SHALL flag a pending access from requester N.
REQ-006 Ports reqN_ready  output  1 SHALL accept requester N's command; transfer occurs when valid and ready are both 1.
REQ-007 Ports reqN_we  input  1 SHALL select write (1) or read (0).
REQ-008 Ports reqN_addr  input  ADDR_WIDTH SHALL carry the word address.
REQ-009 Ports reqN_wdata  input  DATA_WIDTH SHALL carry write data.
REQ-010 Ports respN_valid  output  1 SHALL pulse one cycle when requester N's access completes.
REQ-011 Ports respN_rdata  output  DATA_WIDTH SHALL carry read data, valid only while respN_valid=1.
REQ-012 Port ram_cs_n  output  1 SHALL be the active-low RAM chip select.
REQ-013 Port ram_we  output  1 SHALL be the RAM write enable.
REQ-014 Port ram_addr  output  ADDR_WIDTH SHALL be the RAM address.
REQ-015 Port ram_din  output  DATA_WIDTH SHALL be the RAM write data.
REQ-016 Port ram_dout  input  DATA_WIDTH SHALL be RAM read data, registered: valid the cycle after a read enable.
REQ-017 Port busy  output  1 SHALL be 1 whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS on handshake, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-019 reqN_ready SHALL be combinational, 1 only in IDLE for the granted requester; both readies never 1 together.
REQ-020 Grant in IDLE: only one valid -> that one; both valid -> requester not equal to last_grant register (round-robin).
REQ-021 last_grant SHALL update to the granted index on each handshake only.
REQ-022 On handshake, we/addr/wdata and requester index SHALL be latched into command registers; requester inputs are don't-care afterward.
REQ-023 In ACCESS, ram_cs_n=0, ram_we/ram_addr/ram_din SHALL be driven from command registers; in IDLE and RESP ram_cs_n=1, ram_we=0.
REQ-024 In RESP, respN_valid SHALL be 1 for the latched requester only, for both reads and writes (write acknowledge).
REQ-025 In RESP for a read, respN_rdata SHALL equal ram_dout; for a write, respN_rdata SHALL be 0.
REQ-026 Latency SHALL be: handshake cycle T, RAM enable T+1, response T+2; next handshake earliest T+3 (one access per 3 cycles).
REQ-027 A requester holding valid without grant SHALL wait; a valid dropped before handshake SHALL be ignored without error.
REQ-028 No response backpressure: respN_valid is a single-cycle pulse and SHALL not be held.
REQ-029 Addresses SHALL pass unmodified; no range check (all 2^ADDR_WIDTH addresses legal).

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, last_grant=1, command registers 0, ram_cs_n=1, ram_we=0, ram_addr=0, ram_din=0, respN_valid=0, respN_rdata=0, busy=0.
REQ-031 Reset mid-access SHALL abort it with no response pulse; first grant after reset with both valid SHALL go to requester 0.
REQ-032 RAM contents are not cleared by this block.

Verification
REQ-033 After reset, req0 write addr 5 data 0xA5 -> ready0=1 cycle T, ram_cs_n=0 ram_we=1 addr 5 at T+1, resp0_valid at T+2, busy 1 for T+1..T+2.
REQ-034 Then req1 read addr 5 -> resp1_valid at T+2 with resp1_rdata=0xA5, resp0_valid stays 0.
REQ-035 Both valid continuously for 4 grants from reset -> grant order 0,1,0,1, handshakes 3 cycles apart.
REQ-036 req0 write addr 63 (all-ones address), data all ones, then read addr 63 -> rdata all ones; addr 0 read still returns prior value.
REQ-037 rst_n asserted during ACCESS -> outputs at reset values same cycle, no resp pulse, next grant with both valid to req0.
REQ-038 req1 raises valid while state is ACCESS -> ready1 stays 0 until IDLE, then handshake and correct response.
